// File: rtl/cp0_wb.sv
// Writeback-stage coprocessor 0: SR, Cause, EPC and PRId with interrupt/exception
// entry, eret return and mtc0/mfc0 access.
module cp0_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic [31:2] PC_in,
  input  logic [6:2]  ExcCode_in,
  input  logic        BD_in,
  input  logic        eret_in,
  input  logic        mtc0_in,
  input  logic        mfc0_in,
  input  logic [4:0]  CP0_RD_in,
  input  logic [31:0] CP0_Wdata_in,
  input  logic [7:2]  HWInt,
  output logic [31:0] Rdata_out,
  output logic        Flush_out,
  output logic [31:2] NPC_out,
  output logic [31:2] EPC_out
);

  localparam logic [4:0]  REG_SR     = 5'd12;
  localparam logic [4:0]  REG_CAUSE  = 5'd13;
  localparam logic [4:0]  REG_EPC    = 5'd14;
  localparam logic [4:0]  REG_PRID   = 5'd15;
  localparam logic [31:0] PRID_VAL   = 32'h0000_4D50;
  localparam logic [29:0] HANDLER_PC = 30'h0000_1060;
  localparam logic [29:0] EPC_RESET  = 30'h0000_0C00;

  logic [5:0]  sr_im_r;
  logic        sr_exl_r;
  logic        sr_ie_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  cause_exc_r;
  logic [29:0] epc_r;

  logic int_req_s;
  logic exc_s;
  logic entry_s;
  logic eret_s;
  logic mtc0_s;
  logic unused_s;

  // mfc0 only selects Rdata_out, which is always driven; the flag itself has no effect.
  assign unused_s = mfc0_in;

  assign int_req_s = (|(HWInt & sr_im_r)) & sr_ie_r & ~sr_exl_r;
  assign exc_s     = (ExcCode_in != 5'd0);
  assign entry_s   = EN & (int_req_s | exc_s);
  assign eret_s    = EN & ~entry_s & eret_in;
  assign mtc0_s    = EN & ~entry_s & ~eret_in & mtc0_in;
  assign EPC_out   = epc_r;

  // Zero-latency redirect; forced quiet while reset is held.
  always_comb begin
    Flush_out = 1'b0;
    NPC_out   = 30'h0000_0000;
    if (!rst_n) begin
      Flush_out = 1'b0;
      NPC_out   = 30'h0000_0000;
    end else if (entry_s) begin
      Flush_out = 1'b1;
      NPC_out   = HANDLER_PC;
    end else if (eret_s) begin
      Flush_out = 1'b1;
      NPC_out   = epc_r;
    end else begin
      Flush_out = 1'b0;
      NPC_out   = 30'h0000_0000;
    end
  end

  // CP0 register read mux.
  always_comb begin
    Rdata_out = 32'h0000_0000;
    case (CP0_RD_in)
      REG_SR:    Rdata_out = {16'h0000, sr_im_r, 8'h00, sr_exl_r, sr_ie_r};
      REG_CAUSE: Rdata_out = {cause_bd_r, 15'h0000, cause_ip_r, 3'b000, cause_exc_r, 2'b00};
      REG_EPC:   Rdata_out = {epc_r, 2'b00};
      REG_PRID:  Rdata_out = PRID_VAL;
      default:   Rdata_out = 32'h0000_0000;
    endcase
  end

  // Architectural state update; Cause.IP tracks HWInt even when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im_r     <= 6'd0;
      sr_exl_r    <= 1'b0;
      sr_ie_r     <= 1'b0;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= EPC_RESET;
    end else begin
      cause_ip_r <= HWInt;
      if (entry_s) begin
        sr_exl_r    <= 1'b1;
        cause_bd_r  <= BD_in;
        cause_exc_r <= int_req_s ? 5'd0 : ExcCode_in;
        epc_r       <= BD_in ? (PC_in - 30'd1) : PC_in;
      end else if (eret_s) begin
        sr_exl_r <= 1'b0;
      end else if (mtc0_s) begin
        case (CP0_RD_in)
          REG_SR: begin
            sr_im_r  <= CP0_Wdata_in[15:10];
            sr_exl_r <= CP0_Wdata_in[1];
            sr_ie_r  <= CP0_Wdata_in[0];
          end
          REG_EPC: epc_r <= CP0_Wdata_in[31:2];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_wb.sv
// Directed-vector bench for cp0_wb with immediate-assertion checks.
module tb_cp0_wb;

  logic        clk;
  logic        rst_n;
  logic        EN;
  logic [31:2] PC_in;
  logic [6:2]  ExcCode_in;
  logic        BD_in;
  logic        eret_in;
  logic        mtc0_in;
  logic        mfc0_in;
  logic [4:0]  CP0_RD_in;
  logic [31:0] CP0_Wdata_in;
  logic [7:2]  HWInt;
  logic [31:0] Rdata_out;
  logic        Flush_out;
  logic [31:2] NPC_out;
  logic [31:2] EPC_out;

  int vectors;
  int miscompares;

  cp0_wb dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .PC_in(PC_in), .ExcCode_in(ExcCode_in),
    .BD_in(BD_in), .eret_in(eret_in), .mtc0_in(mtc0_in), .mfc0_in(mfc0_in),
    .CP0_RD_in(CP0_RD_in), .CP0_Wdata_in(CP0_Wdata_in), .HWInt(HWInt),
    .Rdata_out(Rdata_out), .Flush_out(Flush_out), .NPC_out(NPC_out), .EPC_out(EPC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] r, input logic [31:0] exp);
    CP0_RD_in = r;
    #1;
    chk(tag, Rdata_out, exp);
  endtask

  task automatic clr();
    EN = 1'b0; PC_in = 30'd0; ExcCode_in = 5'd0; BD_in = 1'b0;
    eret_in = 1'b0; mtc0_in = 1'b0; mfc0_in = 1'b0;
    CP0_RD_in = 5'd0; CP0_Wdata_in = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    clr(); EN = 1'b1; mtc0_in = 1'b1; CP0_RD_in = r; CP0_Wdata_in = d;
    tick(); clr();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1; HWInt = 6'd0; clr();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_flush", {31'd0, Flush_out}, 32'd0);
    chk("rst_npc", {2'b00, NPC_out}, 32'd0);
    chk("rst_epc_out", {2'b00, EPC_out}, 32'h0000_0C00);
    rd("rst_rd_epc", 5'd14, 32'h0000_3000);
    rd("rst_rd_sr", 5'd12, 32'h0000_0000);
    rd("rst_rd_cause", 5'd13, 32'h0000_0000);
    rd("rst_rd_prid", 5'd15, 32'h0000_4D50);
    rd("rd_unmapped", 5'd3, 32'h0000_0000);
    rst_n = 1'b1;
    tick();

    // Interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    rd("sr_after_mtc0", 5'd12, 32'h0000_0401);
    EN = 1'b1; HWInt = 6'b000001; PC_in = 30'h0000_0C10; BD_in = 1'b0;
    #1;
    chk("int_flush", {31'd0, Flush_out}, 32'd1);
    chk("int_npc", {2'b00, NPC_out}, 32'h0000_1060);
    tick(); clr();
    chk("int_epc_out", {2'b00, EPC_out}, 32'h0000_0C10);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0000_0400);
    EN = 1'b1;
    #1;
    chk("int_masked_by_exl", {31'd0, Flush_out}, 32'd0);
    tick(); clr();

    // Nested delay-slot exception
    HWInt = 6'd0; EN = 1'b1; ExcCode_in = 5'd10; BD_in = 1'b1; PC_in = 30'h0000_0C21;
    #1;
    chk("exc_flush", {31'd0, Flush_out}, 32'd1);
    chk("exc_npc", {2'b00, NPC_out}, 32'h0000_1060);
    tick(); clr();
    chk("exc_epc_out", {2'b00, EPC_out}, 32'h0000_0C20);
    rd("exc_cause", 5'd13, 32'h8000_0028);
    rd("exc_sr", 5'd12, 32'h0000_0403);

    // eret
    EN = 1'b1; eret_in = 1'b1;
    #1;
    chk("eret_flush", {31'd0, Flush_out}, 32'd1);
    chk("eret_npc", {2'b00, NPC_out}, 32'h0000_0C20);
    tick(); clr();
    rd("eret_sr", 5'd12, 32'h0000_0401);

    // Stall then priority: interrupt beats ExcCode 4
    HWInt = 6'b000001; ExcCode_in = 5'd4; PC_in = 30'h0000_0C30; EN = 1'b0;
    #1;
    chk("stall_flush", {31'd0, Flush_out}, 32'd0);
    tick();
    rd("stall_sr", 5'd12, 32'h0000_0401);
    rd("stall_cause", 5'd13, 32'h8000_0428);
    chk("stall_epc_out", {2'b00, EPC_out}, 32'h0000_0C20);
    CP0_RD_in = 5'd0; ExcCode_in = 5'd4; PC_in = 30'h0000_0C30; EN = 1'b1;
    #1;
    chk("prio_flush", {31'd0, Flush_out}, 32'd1);
    chk("prio_npc", {2'b00, NPC_out}, 32'h0000_1060);
    tick(); clr();
    rd("prio_cause", 5'd13, 32'h0000_0400);
    chk("prio_epc_out", {2'b00, EPC_out}, 32'h0000_0C30);
    rd("prio_sr", 5'd12, 32'h0000_0403);
    HWInt = 6'd0; EN = 1'b1; eret_in = 1'b1;
    #1;
    chk("eret2_npc", {2'b00, NPC_out}, 32'h0000_0C30);
    tick(); clr();

    // mtc0 masking
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("sr_mask", 5'd12, 32'h0000_FC03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_wr_ignored", 5'd13, 32'h0000_0000);
    mtc0(5'd14, 32'h1234_567B);
    chk("epc_wr_out", {2'b00, EPC_out}, 32'h048D_159E);
    rd("epc_wr_rd", 5'd14, 32'h1234_5678);

    // eret and mtc0 EPC together: eret wins
    EN = 1'b1; eret_in = 1'b1; mtc0_in = 1'b1; CP0_RD_in = 5'd14; CP0_Wdata_in = 32'd0;
    #1;
    chk("eret_mtc0_npc", {2'b00, NPC_out}, 32'h048D_159E);
    tick(); clr();
    chk("eret_mtc0_epc", {2'b00, EPC_out}, 32'h048D_159E);
    rd("eret_mtc0_sr", 5'd12, 32'h0000_FC01);

    // Cause.IP sampled while stalled with interrupt pending
    HWInt = 6'b101010;
    #1;
    chk("ip_stall_flush", {31'd0, Flush_out}, 32'd0);
    tick();
    rd("ip_stall_cause", 5'd13, 32'h0000_A800);

    // EPC wrap for delay slot at PC 0
    HWInt = 6'd0; CP0_RD_in = 5'd0; EN = 1'b1; ExcCode_in = 5'd1; BD_in = 1'b1; PC_in = 30'd0;
    tick(); clr();
    chk("wrap_epc", {2'b00, EPC_out}, 32'h3FFF_FFFF);
    rd("wrap_cause", 5'd13, 32'h8000_0004);
    rd("wrap_sr", 5'd12, 32'h0000_FC03);

    // Reset asserted mid-handler with an event in flight
    EN = 1'b1; ExcCode_in = 5'd3; CP0_RD_in = 5'd12;
    #1;
    chk("inflight_flush", {31'd0, Flush_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flush", {31'd0, Flush_out}, 32'd0);
    chk("midrst_npc", {2'b00, NPC_out}, 32'd0);
    chk("midrst_epc", {2'b00, EPC_out}, 32'h0000_0C00);
    rd("midrst_sr", 5'd12, 32'h0000_0000);
    tick();
    rd("midrst_sr_hold", 5'd12, 32'h0000_0000);
    rst_n = 1'b1; clr();
    tick();
    rd("post_rst_sr", 5'd12, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
